bk_slot_streamer: RTL and testbench

//  Parametrised save-state/backup streamer between the core's backup RAM port and the hps_io SD sector

---
 rtl/bk_pkg.sv | 21 ++
 rtl/bk_slot_streamer.sv | 161 ++++++++++++++++
 tb/tb_bk_slot_streamer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bk_pkg.sv
// Shared types and helpers for the backup-slot streamer.
package bk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    DONE,
    ERR
  } bk_state_t;

  localparam int unsigned SECTOR_BYTES = 512;

  // Sector address of a slot: slot index in the upper bits, sector offset below.
  function automatic logic [31:0] bk_lba(input logic [31:0] slot_idx,
                                         input logic [31:0] sec_idx,
                                         input int unsigned sec_w);
    return (slot_idx << sec_w) | sec_idx;
  endfunction

endpackage

// File: rtl/bk_slot_streamer.sv
// Save-state streamer: qualifies the mounted backup image and moves one slot
// of sectors between the core's backup RAM port and the hps_io SD interface.
module bk_slot_streamer
  import bk_pkg::*;
#(
  parameter int unsigned SLOTS        = 4,
  parameter int unsigned SEC_PER_SLOT = 64,
  parameter int unsigned ACK_TIMEOUT  = 2**20,
  localparam int unsigned SLOT_W      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              downloading,
  input  logic              img_mounted,
  input  logic              img_readonly,
  input  logic [63:0]       img_size,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              abort,
  input  logic [SLOT_W-1:0] slot,
  input  logic              sd_ack,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              bk_ena,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned SEC_W  = $clog2(SEC_PER_SLOT);
  localparam int unsigned SEC_CW = (SEC_W > 0) ? SEC_W : 1;
  localparam int unsigned WD_W   = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [SEC_CW-1:0] SEC_LAST = SEC_CW'(SEC_PER_SLOT - 1);
  localparam logic [WD_W-1:0]   WD_LAST  = WD_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [63:0]       MIN_IMG  = 64'(SLOTS) * 64'(SEC_PER_SLOT) * 64'(SECTOR_BYTES);

  bk_state_t         state_q, state_d;
  logic              op_load_q, op_load_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SEC_CW-1:0] sec_q, sec_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              bk_ena_q, bk_ena_d;
  logic              bad_slot_q, bad_slot_d;
  logic              dl_q, ack_q, ld_q, sv_q;

  logic ld_lvl, sv_lvl, ld_rise, sv_rise;
  logic dl_rise, ack_rise, ack_fall;

  // Request edges are taken on the gated level so an image arriving under a
  // held request does not look like a fresh press until bk_ena is valid.
  assign ld_lvl   = load_req & bk_ena_q;
  assign sv_lvl   = save_req & bk_ena_q;
  assign ld_rise  = ld_lvl & ~ld_q;
  assign sv_rise  = sv_lvl & ~sv_q;
  assign dl_rise  = downloading & ~dl_q;
  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_load_q  <= 1'b0;
      slot_q     <= '0;
      sec_q      <= '0;
      wd_q       <= '0;
      bk_ena_q   <= 1'b0;
      bad_slot_q <= 1'b0;
      dl_q       <= 1'b0;
      ack_q      <= 1'b0;
      ld_q       <= 1'b0;
      sv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_load_q  <= op_load_d;
      slot_q     <= slot_d;
      sec_q      <= sec_d;
      wd_q       <= wd_d;
      bk_ena_q   <= bk_ena_d;
      bad_slot_q <= bad_slot_d;
      dl_q       <= downloading;
      ack_q      <= sd_ack;
      ld_q       <= ld_lvl;
      sv_q       <= sv_lvl;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_load_d  = op_load_q;
    slot_d     = slot_q;
    sec_d      = sec_q;
    wd_d       = wd_q;
    bk_ena_d   = bk_ena_q;
    bad_slot_d = 1'b0;

    if (dl_rise) begin
      bk_ena_d = 1'b0;
    end else if (downloading && img_mounted && !img_readonly && (img_size >= MIN_IMG)) begin
      bk_ena_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Load has priority; a coincident save edge is consumed and dropped.
        if (ld_rise || sv_rise) begin
          if (32'(slot) >= SLOTS) begin
            bad_slot_d = 1'b1;
          end else begin
            state_d   = REQ;
            op_load_d = ld_rise;
            slot_d    = slot;
            sec_d     = '0;
            wd_d      = '0;
          end
        end
      end
      REQ: begin
        if (abort || dl_rise) begin
          state_d = ERR;
        end else if (ack_rise) begin
          state_d = XFER;
        end else if (ACK_TIMEOUT != 0) begin
          if (wd_q == WD_LAST) begin
            state_d = ERR;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      XFER: begin
        if (abort || dl_rise) begin
          state_d = ERR;
        end else if (ack_fall) begin
          if (sec_q == SEC_LAST) begin
            state_d = DONE;
          end else begin
            sec_d   = sec_q + 1'b1;
            wd_d    = '0;
            state_d = REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign sd_lba     = bk_lba(32'(slot_q), 32'(sec_q), SEC_W);
  assign sd_rd      = (state_q == REQ) & op_load_q;
  assign sd_wr      = (state_q == REQ) & ~op_load_q;
  assign bk_busy    = (state_q == REQ) | (state_q == XFER);
  assign bk_loading = bk_busy & op_load_q;
  assign bk_ena     = bk_ena_q;
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR) | bad_slot_q;

endmodule

// File: tb/tb_bk_slot_streamer.sv
// Self-checking bench for bk_slot_streamer: randomized ack timing and transfers
// checked against a transaction-level model of the slot/sector rules.
module tb_bk_slot_streamer;

  localparam int unsigned SLOTS = 4;
  localparam int unsigned SPS   = 64;
  localparam int unsigned TMO   = 100;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        downloading = 1'b0;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic        load_req = 1'b0;
  logic        save_req = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  slot = '0;
  logic        sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, done, error;

  bit          ack_en = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bk_slot_streamer #(
    .SLOTS       (SLOTS),
    .SEC_PER_SLOT(SPS),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .downloading (downloading),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .img_size    (img_size),
    .load_req    (load_req),
    .save_req    (save_req),
    .abort       (abort),
    .slot        (slot),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .bk_ena      (bk_ena),
    .bk_loading  (bk_loading),
    .bk_busy     (bk_busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // hps_io stand-in: random latency, random pulse width per sector request.
  initial begin : hps_ack
    forever begin
      @(negedge clk_sys);
      if (ack_en && reset_n && (sd_rd || sd_wr)) begin
        repeat ($urandom_range(0, 4)) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat ($urandom_range(1, 10)) @(negedge clk_sys);
        sd_ack = 1'b0;
      end
    end
  end

  initial begin : global_watchdog
    #3000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  task automatic mount(input logic [63:0] size, input bit ro, input string tag);
    bit exp_ena;
    exp_ena = !ro && (size >= 64'(SLOTS) * 64'(SPS) * 64'd512);
    @(negedge clk_sys);
    downloading = 1'b1;
    @(posedge clk_sys); #1;
    check_eq({tag, "_clr"}, bk_ena, 0);
    @(negedge clk_sys);
    img_size     = size;
    img_readonly = ro;
    img_mounted  = 1'b1;
    @(negedge clk_sys);
    img_mounted  = 1'b0;
    downloading  = 1'b0;
    @(posedge clk_sys); #1;
    check_eq(tag, bk_ena, exp_ena);
  endtask

  task automatic run_xfer(input bit op_load, input bit both, input logic [1:0] sl, input int abort_at);
    int unsigned nreq, cyc, ndone, nerr, abort_cyc, poke_cyc;
    bit prev_req, prev_ack, finished, poked, abort_set, exp_load;
    bit lba_ok, dir_ok, flag_ok, done_ok, err_ok;
    nreq = 0; cyc = 0; ndone = 0; nerr = 0; abort_cyc = 0; poke_cyc = 0;
    prev_req = 0; prev_ack = sd_ack; finished = 0; poked = 0; abort_set = 0;
    lba_ok = 1; dir_ok = 1; flag_ok = 1; done_ok = 1; err_ok = 1;
    exp_load = op_load | both;
    @(negedge clk_sys);
    slot     = sl;
    load_req = op_load | both;
    save_req = !op_load | both;
    while (!finished && cyc < 3000) begin
      @(posedge clk_sys); #1;
      cyc++;
      if (cyc == 1) check_eq("start_latency", {sd_rd, sd_wr}, exp_load ? 2'b10 : 2'b01);
      if (cyc == 2) slot = 2'($urandom);
      if (abort_set && cyc == abort_cyc + 1) abort = 1'b0;
      if (poked && cyc == poke_cyc + 1) begin
        if (exp_load) save_req = 1'b0; else load_req = 1'b0;
      end
      if ((sd_rd || sd_wr) && !prev_req) begin
        if (sd_lba !== 32'(sl) * SPS + nreq) lba_ok = 0;
        if (sd_rd !== exp_load || sd_wr !== !exp_load) dir_ok = 0;
        if (abort_at >= 0 && nreq == unsigned'(abort_at)) begin
          abort = 1'b1; abort_set = 1; abort_cyc = cyc;
        end
        nreq++;
      end
      if (!both && !poked && nreq == 6) begin
        if (exp_load) save_req = 1'b1; else load_req = 1'b1;
        poked = 1; poke_cyc = cyc;
      end
      if (done || error) finished = 1;
      else if (bk_busy !== 1'b1 || bk_loading !== exp_load) flag_ok = 0;
      if (done) begin
        ndone++;
        if (!(prev_ack && !sd_ack)) done_ok = 0;
      end
      if (error) begin
        nerr++;
        if (!(abort_set && cyc == abort_cyc + 1 && !sd_rd && !sd_wr)) err_ok = 0;
      end
      prev_req = sd_rd | sd_wr;
      prev_ack = sd_ack;
    end
    load_req = 1'b0; save_req = 1'b0; abort = 1'b0;
    check_eq("xfer_finished", finished, 1);
    check_eq("xfer_lba_seq", lba_ok, 1);
    check_eq("xfer_direction", dir_ok, 1);
    check_eq("xfer_busy_loading", flag_ok, 1);
    check_eq("xfer_done_latency", done_ok, 1);
    check_eq("xfer_err_on_abort", err_ok, 1);
    if (abort_at >= 0) begin
      check_eq("abort_nreq", nreq, unsigned'(abort_at) + 1);
      check_eq("abort_ndone", ndone, 0);
      check_eq("abort_nerr", nerr, 1);
    end else begin
      check_eq("xfer_nreq", nreq, SPS);
      check_eq("xfer_ndone", ndone, 1);
      check_eq("xfer_nerr", nerr, 0);
    end
    @(posedge clk_sys); #1;
    check_eq("pulse_width", {done, error}, 0);
    repeat (12) @(posedge clk_sys);
    #1;
    check_eq("idle_after", {bk_busy, bk_loading, sd_rd, sd_wr}, 0);
  endtask

  task automatic run_timeout();
    int unsigned cyc, rd_cnt, err_at;
    bit seen;
    cyc = 0; rd_cnt = 0; err_at = 0; seen = 0;
    ack_en = 1'b0;
    repeat (20) @(negedge clk_sys);
    slot = 2'd3;
    load_req = 1'b1;
    while (!seen && cyc < 400) begin
      @(posedge clk_sys); #1;
      cyc++;
      if (cyc == 1) check_eq("tmo_lba", sd_lba, 3 * SPS);
      if (sd_rd) rd_cnt++;
      if (error) begin
        seen = 1;
        err_at = cyc;
        check_eq("tmo_rd_clear", {sd_rd, sd_wr}, 0);
      end
    end
    load_req = 1'b0;
    check_eq("tmo_err_cycle", err_at, TMO + 1);
    check_eq("tmo_rd_cycles", rd_cnt, TMO);
    @(posedge clk_sys); #1;
    check_eq("tmo_idle", {bk_busy, error, sd_rd, done}, 0);
    ack_en = 1'b1;
  endtask

  task automatic run_reset_mid();
    int unsigned cyc;
    bit activity;
    cyc = 0; activity = 0;
    @(negedge clk_sys);
    slot = 2'd2;
    load_req = 1'b1;
    while (sd_ack !== 1'b1 && cyc < 60) begin
      @(posedge clk_sys); #1;
      cyc++;
    end
    @(posedge clk_sys); #1;
    check_eq("rst_pre_busy", bk_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_async_outputs",
             {sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, done, error}, 0);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (100) begin
      @(posedge clk_sys); #1;
      if (sd_rd || sd_wr || bk_busy || done || error) activity = 1;
    end
    check_eq("rst_held_level_no_xfer", activity, 0);
    load_req = 1'b0;
  endtask

  initial begin : main
    bit gated_act;
    bit op;
    int ab;
    gated_act = 0;
    repeat (3) @(negedge clk_sys);
    check_eq("reset_outputs",
             {sd_lba, sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, done, error}, 0);
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    check_eq("reset_bk_ena", bk_ena, 0);

    mount(64'd65536, 1'b0, "bkena_small");
    @(negedge clk_sys);
    save_req = 1'b1;
    repeat (20) begin
      @(posedge clk_sys); #1;
      if (sd_rd || sd_wr || bk_busy) gated_act = 1;
    end
    save_req = 1'b0;
    check_eq("gated_no_xfer", gated_act, 0);

    mount(64'd131072, 1'b1, "bkena_ro");
    mount(64'd131072, 1'b0, "bkena_ok");
    mount(64'd131071, 1'b0, "bkena_one_short");
    mount(64'd262144, 1'b0, "bkena_large");

    run_xfer(1'b0, 1'b0, 2'd2, -1);
    run_xfer(1'b1, 1'b1, 2'd1, -1);
    run_timeout();
    run_xfer(1'b0, 1'b0, 2'd0, 10);
    run_xfer(1'b0, 1'b0, 2'd0, -1);

    for (int i = 0; i < 4; i++) begin
      op = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) ab = int'($urandom_range(0, SPS - 1));
      else ab = -1;
      run_xfer(op, 1'b0, 2'($urandom_range(0, SLOTS - 1)), ab);
    end
    run_xfer(1'b1, 1'b0, 2'd3, SPS - 1);

    run_reset_mid();
    mount(64'd131072, 1'b0, "bkena_after_reset");
    run_xfer(1'b1, 1'b0, 2'd3, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
